// File: rtl/mealy_stream_if.sv
// Parallel-side handshake and result bundle for the serial ones-tracking sequencer.
// The master drives start/clear_state/data_in; the slave (sequencer) returns status and results.
interface mealy_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             clear_state;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y_word;
    logic [CNT_W-1:0] ones_cnt;
    logic [1:0]       det_state;

    modport master (
        output start, clear_state, data_in,
        input  busy, done, y_word, ones_cnt, det_state
    );

    modport slave (
        input  start, clear_state, data_in,
        output busy, done, y_word, ones_cnt, det_state
    );
endinterface

// File: rtl/mealy_stream_ctrl.sv
// Sequencer that shifts a parallel word LSB-first through the 4-state Mealy
// ones-tracking detector, collecting per-bit outputs and their ones count.
module mealy_stream_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic           clk,
    input  logic           rstn,
    mealy_stream_if.slave  bus
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] CTRL_IDLE  = 2'd0;
    localparam logic [1:0] CTRL_SHIFT = 2'd1;
    localparam logic [1:0] CTRL_DONE  = 2'd2;

    localparam logic [1:0] DET_S0 = 2'b00;
    localparam logic [1:0] DET_S1 = 2'b01;
    localparam logic [1:0] DET_S2 = 2'b10;
    localparam logic [1:0] DET_S3 = 2'b11;

    logic [1:0]       ctrl_q,     ctrl_d;
    logic [WIDTH-1:0] sh_q,       sh_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [WIDTH-1:0] y_word_q,   y_word_d;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [1:0]       det_q,      det_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic             x_c;
    logic             y_c;
    logic [1:0]       det_nxt_c;

    // Embedded Mealy detector: next state and output from (state, x)
    always_comb begin
        x_c       = sh_q[0];
        y_c       = 1'b0;
        det_nxt_c = det_q;
        case (det_q)
            DET_S0: begin
                if (x_c) det_nxt_c = DET_S1;
            end
            DET_S1: begin
                if (x_c) det_nxt_c = DET_S2;
            end
            DET_S2: begin
                y_c = 1'b1;
                if (x_c) det_nxt_c = DET_S3;
            end
            DET_S3: begin
                if (x_c) begin
                    det_nxt_c = DET_S1;
                end else begin
                    y_c = 1'b1;
                end
            end
            default: begin
                det_nxt_c = DET_S0;
            end
        endcase
    end

    // Controller next-state and datapath updates
    always_comb begin
        ctrl_d     = ctrl_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        y_word_d   = y_word_q;
        ones_cnt_d = ones_cnt_q;
        det_d      = det_q;

        case (ctrl_q)
            CTRL_IDLE: begin
                if (bus.start) begin
                    sh_d       = bus.data_in;
                    idx_d      = '0;
                    y_word_d   = '0;
                    ones_cnt_d = '0;
                    if (bus.clear_state) det_d = DET_S0;
                    ctrl_d     = CTRL_SHIFT;
                end
            end
            CTRL_SHIFT: begin
                y_word_d[idx_q] = y_c;
                ones_cnt_d      = ones_cnt_q + CNT_W'(y_c);
                det_d           = det_nxt_c;
                sh_d            = {1'b0, sh_q[WIDTH-1:1]};
                idx_d           = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WIDTH - 1)) ctrl_d = CTRL_DONE;
            end
            CTRL_DONE: begin
                ctrl_d = CTRL_IDLE;
            end
            default: begin
                ctrl_d = CTRL_IDLE;
            end
        endcase

        // Status flags registered from the next controller state
        busy_d = (ctrl_d != CTRL_IDLE);
        done_d = (ctrl_d == CTRL_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q     <= CTRL_IDLE;
            sh_q       <= '0;
            idx_q      <= '0;
            y_word_q   <= '0;
            ones_cnt_q <= '0;
            det_q      <= DET_S0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            y_word_q   <= y_word_d;
            ones_cnt_q <= ones_cnt_d;
            det_q      <= det_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.y_word    = y_word_q;
    assign bus.ones_cnt  = ones_cnt_q;
    assign bus.det_state = det_q;

endmodule
